writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-back stage that drives the register file's write command (writenum/writedata) from two result producers: the single-cycle ALU and the multi-cycle multiplier.
- Results are buffered in a small FIFO and retired at one register write per cycle, in arrival order.
- Keeps a pending-write scoreboard so the issue stage can detect RAW hazards on operand fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
CW, 3, width of count_o; equals log2(DEPTH)+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
alu_valid_i  input  1  ALU result valid
alu_dest_i  input  5  ALU destination register number
alu_data_i  input  32  ALU result
alu_ready_o  output  1  FIFO accepts the ALU result this cycle
mul_valid_i  input  1  multiplier result valid
mul_dest_i  input  5  multiplier destination register number
mul_data_i  input  32  multiplier result
mul_ready_o  output  1  FIFO accepts the multiplier result this cycle
issue_valid_i  input  1  an instruction writing issue_dest_i is issued
issue_dest_i  input  5  destination register of the issued instruction
writenum_o  output  6  register-file write command: bit5 = write enable, bits4:0 = register number
writedata_o  output  32  register-file write data
pending_o  output  32  bit n set = write to register n outstanding
count_o  output  CW  FIFO occupancy

Behaviour:
- Reset, asynchronous: FIFO emptied with pointers 0 and count_o = 0; writenum_o = 0; writedata_o = 0; pending_o = 0.
- Reset mid-operation: all queued results are discarded and no write issues after reset.
- Readiness: combinational from the registered count; free = DEPTH - count_o.
  - No credit is given for a same-cycle dequeue.
  - alu_ready_o = (free >= 1).
  - mul_ready_o = (free >= 2) OR (free == 1 AND NOT alu_valid_i).
  - Both are 1 out of reset.
- Enqueue: up to 2 entries per edge. A transfer occurs when valid and ready are both 1 at the edge.
  - When both transfer on the same edge, the ALU entry is written first, then the multiplier entry, so ALU precedes MUL in write order.
  - Producers hold valid, dest and data stable until ready.
- Dequeue: at each edge with count_o > 0, the head entry is popped and registered to writenum_o = {1, dest} and writedata_o = data.
  - With count_o == 0: writenum_o[5] <= 0, writenum_o[4:0] holds, writedata_o holds.
  - Latency: an entry accepted at edge E into an empty FIFO appears on writenum_o after edge E+1.
  - Sustained throughput is 1 write per cycle.
- count_o' = count_o + enqueued - dequeued. It never exceeds DEPTH and never goes below 0.
- Pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_valid_i sets pending[issue_dest_i] at the edge.
  - The edge that loads writenum_o with {1, n} clears pending[n].
  - Set and clear of the same bit on the same edge: set wins.
  - The issue stage never issues to a register whose pending bit is 1, so there is at most one outstanding write per register.

Optional Feature:
- Macro: WB_ZERO_REG_EN.
- When defined, register 0 is hardwired zero:
  - results with dest 0 complete the handshake but are not enqueued; count_o is unchanged and ready is computed as usual;
  - issue to dest 0 never sets pending_o[0], so pending_o[0] is constantly 0.
- When undefined, register 0 is an ordinary register, handled like every other register.

Test Plan:
- Reset, then ALU r5 = 0x00001234 accepted at edge E -> after E+1: writenum_o = 6'b100101, writedata_o = 0x00001234; after E+2: writenum_o[5] = 0, count_o = 0.
- ALU r3 = 0xA and MUL r4 = 0xB valid on the same edge with FIFO empty -> both accepted, count_o = 2; writes r3 = 0xA then r4 = 0xB on consecutive cycles.
- DEPTH = 4, both producers valid every cycle with distinct dests -> count_o reaches 4 and never exceeds it. mul_ready_o = 0 whenever free <= 1 with ALU valid; alu_ready_o = 0 at free = 0. All accepted results are written exactly once, in order.
- Issue r7 -> pending_o[7] = 1. ALU r7 = 0x55 accepted -> pending_o[7] clears on the edge writenum_o shows 6'b100111. Issue r9 on that same edge -> pending_o[9] = 1.
- Three entries queued, rst_i pulsed mid-cycle -> outputs zero immediately, asynchronously, without waiting for a clock edge; no writes after release; readies = 1.
- WB_ZERO_REG_EN defined: ALU r0 = 0xFF accepted -> count_o stays 0, writenum_o[5] stays 0. Issue r0 -> pending_o[0] = 0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Write-back bundle: ALU/multiplier result handshakes, issue-stage scoreboard
// update, and the register-file write command with status outputs.
interface writeback_unit_if #(
    parameter int CW = 3
);
    logic          alu_valid_i;
    logic [4:0]    alu_dest_i;
    logic [31:0]   alu_data_i;
    logic          alu_ready_o;
    logic          mul_valid_i;
    logic [4:0]    mul_dest_i;
    logic [31:0]   mul_data_i;
    logic          mul_ready_o;
    logic          issue_valid_i;
    logic [4:0]    issue_dest_i;
    logic [5:0]    writenum_o;
    logic [31:0]   writedata_o;
    logic [31:0]   pending_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  alu_valid_i, alu_dest_i, alu_data_i,
        input  mul_valid_i, mul_dest_i, mul_data_i,
        input  issue_valid_i, issue_dest_i,
        output alu_ready_o, mul_ready_o,
        output writenum_o, writedata_o, pending_o, count_o
    );

    modport master (
        output alu_valid_i, alu_dest_i, alu_data_i,
        output mul_valid_i, mul_dest_i, mul_data_i,
        output issue_valid_i, issue_dest_i,
        input  alu_ready_o, mul_ready_o,
        input  writenum_o, writedata_o, pending_o, count_o
    );
endinterface

// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU and multiplier results through a small FIFO into
// one register-file write per cycle, with a pending-write scoreboard. Optional macro: WB_ZERO_REG_EN.
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    writeback_unit_if.slave wb
);
    localparam int PW = $clog2(DEPTH);

`ifdef WB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    function automatic logic [CW-1:0] free_slots(input logic [CW-1:0] cnt);
        return CW'(DEPTH) - cnt;
    endfunction

    function automatic logic kept_dest(input logic [4:0] dest);
        return !ZERO_REG || (dest != 5'd0);
    endfunction

    logic [4:0]    dest_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wptr_p0, rptr_p0, mul_wptr;
    logic [CW-1:0] count_p0, free;
    logic          alu_rdy, mul_rdy, alu_enq, mul_enq, deq;
    logic [1:0]    enq_n;
    logic          vld_p1;
    logic [4:0]    wnum_p1;
    logic [31:0]   wdata_p1;
    logic [31:0]   pending_p1, pending_nxt;

    // Readiness looks only at the registered count; a same-cycle pop earns no credit.
    assign free     = free_slots(count_p0);
    assign alu_rdy  = (free >= CW'(1));
    assign mul_rdy  = (free >= CW'(2)) || ((free == CW'(1)) && !wb.alu_valid_i);
    assign alu_enq  = wb.alu_valid_i && alu_rdy && kept_dest(wb.alu_dest_i);
    assign mul_enq  = wb.mul_valid_i && mul_rdy && kept_dest(wb.mul_dest_i);
    assign mul_wptr = alu_enq ? wptr_p0 + PW'(1) : wptr_p0;
    assign enq_n    = {1'b0, alu_enq} + {1'b0, mul_enq};
    assign deq      = (count_p0 != '0);

    always_comb begin
        pending_nxt = pending_p1;
        if (deq)
            pending_nxt[dest_mem[rptr_p0]] = 1'b0;
        if (wb.issue_valid_i && kept_dest(wb.issue_dest_i))
            pending_nxt[wb.issue_dest_i] = 1'b1;
    end

    // Stage p0: FIFO storage, ALU entry ahead of the multiplier entry
    always_ff @(posedge clk_i) begin
        if (alu_enq) begin
            dest_mem[wptr_p0] <= wb.alu_dest_i;
            data_mem[wptr_p0] <= wb.alu_data_i;
        end
        if (mul_enq) begin
            dest_mem[mul_wptr] <= wb.mul_dest_i;
            data_mem[mul_wptr] <= wb.mul_data_i;
        end
    end

    // Stage p1: head pop into the registered write command
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_p0    <= '0;
            rptr_p0    <= '0;
            count_p0   <= '0;
            vld_p1     <= 1'b0;
            wnum_p1    <= '0;
            wdata_p1   <= '0;
            pending_p1 <= '0;
        end else begin
            wptr_p0    <= wptr_p0 + PW'(enq_n);
            count_p0   <= count_p0 + CW'(enq_n) - CW'(deq);
            pending_p1 <= pending_nxt;
            vld_p1     <= deq;
            if (deq) begin
                rptr_p0  <= rptr_p0 + PW'(1);
                wnum_p1  <= dest_mem[rptr_p0];
                wdata_p1 <= data_mem[rptr_p0];
            end
        end
    end

    assign wb.alu_ready_o = alu_rdy;
    assign wb.mul_ready_o = mul_rdy;
    assign wb.writenum_o  = {vld_p1, wnum_p1};
    assign wb.writedata_o = wdata_p1;
    assign wb.pending_o   = pending_p1;
    assign wb.count_o     = count_p0;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: accepted results are queued in order and
// matched against each register-file write as it appears.
module tb_writeback_unit;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef WB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    writeback_unit_if #(.CW(CW)) wb ();
    writeback_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (wb)
    );

    ent_t        sb[$];
    int          cnt_m   = 0;
    int          max_m   = 0;
    int          max_dut = 0;
    logic [31:0] pend_m  = '0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check readiness, update model, check outputs after the edge.
    task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                        input logic iv, input logic [4:0] idst,
                        output logic a_acc, output logic m_acc);
        int   free;
        logic e_ar, e_mr, deq;
        ent_t hd;
        wb.alu_valid_i   = av;
        wb.alu_dest_i    = ad;
        wb.alu_data_i    = adat;
        wb.mul_valid_i   = mv;
        wb.mul_dest_i    = md;
        wb.mul_data_i    = mdat;
        wb.issue_valid_i = iv;
        wb.issue_dest_i  = idst;
        #1;
        free = DEPTH - cnt_m;
        e_ar = (free >= 1);
        e_mr = (free >= 2) || ((free == 1) && !av);
        check("alu_ready", 32'(wb.alu_ready_o), 32'(e_ar));
        check("mul_ready", 32'(wb.mul_ready_o), 32'(e_mr));
        a_acc = av && e_ar;
        m_acc = mv && e_mr;
        deq   = (cnt_m > 0);
        hd    = '0;
        if (deq) begin
            hd = sb.pop_front();
            pend_m[hd.dest] = 1'b0;
        end
        if (a_acc && !(ZR && ad == 5'd0)) sb.push_back('{dest: ad, data: adat});
        if (m_acc && !(ZR && md == 5'd0)) sb.push_back('{dest: md, data: mdat});
        if (iv && !(ZR && idst == 5'd0)) pend_m[idst] = 1'b1;
        cnt_m = sb.size();
        if (cnt_m > max_m) max_m = cnt_m;
        @(posedge clk_i);
        @(negedge clk_i);
        if (int'(wb.count_o) > max_dut) max_dut = int'(wb.count_o);
        check("write_en", 32'(wb.writenum_o[5]), 32'(deq));
        if (deq) begin
            check("write_num", 32'(wb.writenum_o[4:0]), 32'(hd.dest));
            check("write_data", wb.writedata_o, hd.data);
        end
        check("count", 32'(wb.count_o), 32'(cnt_m));
        check("pending", wb.pending_o, pend_m);
    endtask

    task automatic idle(input int n);
        logic a, m;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a, m);
    endtask

    initial begin
        logic        a, m;
        logic        ha, hm;
        logic [4:0]  hadst, hmdst, seq;
        logic [31:0] hadat, hmdat;
        logic        av;

        rst_i            = 1'b1;
        wb.alu_valid_i   = 0; wb.alu_dest_i = 0; wb.alu_data_i = 0;
        wb.mul_valid_i   = 0; wb.mul_dest_i = 0; wb.mul_data_i = 0;
        wb.issue_valid_i = 0; wb.issue_dest_i = 0;
        #12;
        check("rst_writenum", 32'(wb.writenum_o), 32'h0);
        check("rst_writedata", wb.writedata_o, 32'h0);
        check("rst_pending", wb.pending_o, 32'h0);
        check("rst_count", 32'(wb.count_o), 32'h0);
        check("rst_alu_ready", 32'(wb.alu_ready_o), 32'h1);
        check("rst_mul_ready", 32'(wb.mul_ready_o), 32'h1);
        #1 rst_i = 1'b0;
        @(negedge clk_i);

        // Single ALU write, latency of one edge after acceptance
        step(1, 5'd5, 32'h0000_1234, 0, 0, 0, 0, 0, a, m);
        idle(1);
        check("t1_writenum", 32'(wb.writenum_o), 32'h25);
        idle(1);

        // Simultaneous ALU and MUL: ALU retires first
        step(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 0, 0, a, m);
        idle(3);

        // Scoreboard set/clear, with a set on the clearing edge
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, a, m);
        step(1, 5'd7, 32'h55, 0, 0, 0, 0, 0, a, m);
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, a, m);
        check("t4_writenum", 32'(wb.writenum_o), 32'h27);
        check("t4_p7", 32'(wb.pending_o[7]), 32'h0);
        check("t4_p9", 32'(wb.pending_o[9]), 32'h1);
        idle(2);

        // Back-pressure stress: producers hold until accepted
        ha = 0; hm = 0; seq = 5'd1;
        hadst = 0; hmdst = 0; hadat = 0; hmdat = 0;
        for (int k = 0; k < 60; k++) begin
            if (!ha) begin ha = 1; hadst = seq; seq = seq + 5'd1; hadat = $urandom; end
            if (!hm) begin hm = 1; hmdst = seq; seq = seq + 5'd1; hmdat = $urandom; end
            av = ($urandom_range(0, 3) != 0);
            step(av, hadst, hadat, 1, hmdst, hmdat, 0, 0, a, m);
            if (a) ha = 0;
            if (m) hm = 0;
        end
        idle(5);
        check("stress_drain", 32'(sb.size()), 32'h0);
        check("stress_max_count", 32'(max_dut), 32'(max_m));

        // Asynchronous reset with three entries queued
        step(1, 5'd10, 32'hC0DE_0010, 1, 5'd11, 32'hC0DE_0011, 1, 5'd12, a, m);
        step(1, 5'd13, 32'hC0DE_0013, 1, 5'd14, 32'hC0DE_0014, 0, 0, a, m);
        wb.alu_valid_i = 0; wb.mul_valid_i = 0; wb.issue_valid_i = 0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_writenum", 32'(wb.writenum_o), 32'h0);
        check("arst_writedata", wb.writedata_o, 32'h0);
        check("arst_pending", wb.pending_o, 32'h0);
        check("arst_count", 32'(wb.count_o), 32'h0);
        check("arst_alu_ready", 32'(wb.alu_ready_o), 32'h1);
        check("arst_mul_ready", 32'(wb.mul_ready_o), 32'h1);
        #1 rst_i = 1'b0;
        sb.delete();
        cnt_m  = 0;
        pend_m = '0;
        idle(4);

        // Register 0: hardwired zero when the option is built in, ordinary otherwise
        step(1, 5'd0, 32'hFF, 0, 0, 0, 1, 5'd0, a, m);
        check("r0_pending0", 32'(wb.pending_o[0]), 32'(!ZR));
        idle(1);
        check("r0_write_en", 32'(wb.writenum_o[5]), 32'(!ZR));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
